// File: rtl/imem_arbiter_pkg.sv
// Shared constants and encodings for the instruction-memory arbiter slice.
package imem_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    // Response owner of the access granted in the previous cycle
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LRD   = 2'd2
    } owner_e;

    // One-hot grant vector positions for rr_arb2
    localparam logic [1:0] GNT_NONE   = 2'b00;
    localparam logic [1:0] GNT_FETCH  = 2'b01;
    localparam logic [1:0] GNT_LOADER = 2'b10;

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between fetch stage, program loader, instruction memory and the arbiter.
interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    logic            f_req;
    logic [XLEN-1:0] f_addr;
    logic            f_gnt;
    logic            f_rvalid;
    logic [XLEN-1:0] f_rdata;

    logic            l_req;
    logic            l_we;
    logic [XLEN-1:0] l_addr;
    logic [XLEN-1:0] l_wdata;
    logic            l_lock;
    logic            l_gnt;
    logic            l_rvalid;
    logic [XLEN-1:0] l_rdata;

    logic [XLEN-1:0] mem_addr;
    logic            mem_we;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
               mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/imem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; bit 0 = fetch, bit 1 = loader. A set mask bit
// removes that requester from arbitration for the cycle.
module rr_arb2
    import imem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] eff_req_s;
    logic [1:0] gnt_s;
    logic       last_r;      // 1 = loader won the most recent grant
    logic       last_nxt_s;

    // Grant selection and last-grant update
    always_comb begin
        eff_req_s  = req & ~mask;
        gnt_s      = GNT_NONE;
        last_nxt_s = last_r;
        if (reset) begin
            gnt_s = GNT_NONE;
        end else begin
            case (eff_req_s)
                2'b01:   gnt_s = GNT_FETCH;
                2'b10:   gnt_s = GNT_LOADER;
                2'b11:   gnt_s = last_r ? GNT_FETCH : GNT_LOADER;
                default: gnt_s = GNT_NONE;
            endcase
        end
        if (gnt_s[1]) begin
            last_nxt_s = 1'b1;
        end else if (gnt_s[0]) begin
            last_nxt_s = 1'b0;
        end else begin
            last_nxt_s = last_r;
        end
    end

    // Last-grant register; starts as "fetch" so the loader wins the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            last_r <= 1'b0;
        end else begin
            last_r <= last_nxt_s;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/imem_arbiter.sv
// Shares a single-port synchronous-read instruction memory between fetch and
// loader, one access per cycle, and returns read data to the owner 2 cycles later.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    // Equals (1 << XLEN) / XLEN without needing a wider-than-XLEN intermediate
    parameter int unsigned NWORDS = 32'd1 << (XLEN - $clog2(XLEN))
) (
    input  logic          clk,
    input  logic          reset,
    imem_arbiter_if.slave bus
);

    // Keeps only the word-index bits, so addresses wrap modulo NWORDS*4
    localparam logic [XLEN-1:0] ADDR_MASK = XLEN'((NWORDS - 32'd1) << 2);

    logic [1:0]      gnt_s;
    logic [XLEN-1:0] mem_addr_s;
    logic            mem_we_s;
    logic [XLEN-1:0] mem_wdata_s;
    owner_e          owner_nxt_s;

    owner_e          owner_r;
    logic [XLEN-1:0] addr_hold_r;
    logic            f_rvalid_r;
    logic [XLEN-1:0] f_rdata_r;
    logic            l_rvalid_r;
    logic [XLEN-1:0] l_rdata_r;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .reset (reset),
        .req   ({bus.l_req, bus.f_req}),
        .mask  ({1'b0, bus.l_lock}),
        .gnt   (gnt_s)
    );

    // Memory drive from the winner and owner tag for next cycle's response
    always_comb begin
        mem_addr_s  = addr_hold_r;
        mem_we_s    = 1'b0;
        mem_wdata_s = {XLEN{1'b0}};
        owner_nxt_s = OWN_NONE;
        if (gnt_s[1]) begin
            mem_addr_s  = bus.l_addr & ADDR_MASK;
            mem_we_s    = bus.l_we;
            mem_wdata_s = bus.l_we ? bus.l_wdata : {XLEN{1'b0}};
            owner_nxt_s = bus.l_we ? OWN_NONE : OWN_LRD;
        end else if (gnt_s[0]) begin
            mem_addr_s  = bus.f_addr & ADDR_MASK;
            owner_nxt_s = OWN_FETCH;
        end else begin
            mem_addr_s  = addr_hold_r;
            owner_nxt_s = OWN_NONE;
        end
    end

    // Owner pipeline stage and registered read responses
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_r     <= OWN_NONE;
            addr_hold_r <= {XLEN{1'b0}};
            f_rvalid_r  <= 1'b0;
            f_rdata_r   <= {XLEN{1'b0}};
            l_rvalid_r  <= 1'b0;
            l_rdata_r   <= {XLEN{1'b0}};
        end else begin
            owner_r     <= owner_nxt_s;
            addr_hold_r <= mem_addr_s;
            f_rvalid_r  <= (owner_r == OWN_FETCH);
            l_rvalid_r  <= (owner_r == OWN_LRD);
            if (owner_r == OWN_FETCH) begin
                f_rdata_r <= bus.mem_rdata;
            end else begin
                f_rdata_r <= f_rdata_r;
            end
            if (owner_r == OWN_LRD) begin
                l_rdata_r <= bus.mem_rdata;
            end else begin
                l_rdata_r <= l_rdata_r;
            end
        end
    end

    assign bus.f_gnt     = gnt_s[0];
    assign bus.l_gnt     = gnt_s[1];
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_we    = mem_we_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.f_rvalid  = f_rvalid_r;
    assign bus.f_rdata   = f_rdata_r;
    assign bus.l_rvalid  = l_rvalid_r;
    assign bus.l_rdata   = l_rdata_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a 16-word synchronous-read memory model.
module tb_imem_arbiter;

    localparam int unsigned NW = 16;

    logic clk;
    logic reset;
    logic mem_load;
    int   n_checks;
    int   n_errors;

    logic [31:0] mem [NW];

    imem_arbiter_if bus ();

    imem_arbiter #(.NWORDS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preload pattern A000_0000 + index, 1-cycle read latency
    always @(posedge clk) begin
        if (mem_load) begin
            for (int k = 0; k < NW; k++) mem[k] <= 32'hA000_0000 + 32'(k);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[5:2]];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        mem_load = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = 32'h0;
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_addr = 32'h0;
        bus.l_wdata = 32'h0; bus.l_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mem_load = 1'b0;

        // Reset state
        @(negedge clk);
        check_val("rst_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        check_val("rst_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        check_val("rst_f_rdata", bus.f_rdata, 32'd0);
        check_val("rst_l_rdata", bus.l_rdata, 32'd0);
        check_val("rst_f_gnt", 32'(bus.f_gnt), 32'd0);
        check_val("rst_l_gnt", 32'(bus.l_gnt), 32'd0);
        check_val("rst_mem_we", 32'(bus.mem_we), 32'd0);
        step();

        // Single fetch of 0x8
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        @(negedge clk);
        check_val("f1_gnt", 32'(bus.f_gnt), 32'd1);
        check_val("f1_l_gnt", 32'(bus.l_gnt), 32'd0);
        check_val("f1_mem_addr", bus.mem_addr, 32'h8);
        check_val("f1_mem_we", 32'(bus.mem_we), 32'd0);
        step();
        bus.f_req = 1'b0;
        @(negedge clk);
        check_val("f1_rvalid_early", 32'(bus.f_rvalid), 32'd0);
        step();
        @(negedge clk);
        check_val("f1_rvalid", 32'(bus.f_rvalid), 32'd1);
        check_val("f1_rdata", bus.f_rdata, 32'hA000_0002);
        check_val("f1_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        step();

        // Contention: loader reads 0x14, fetch reads 0xC, grants L,F,L,F
        bus.f_req = 1'b1; bus.f_addr = 32'hC;
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h14;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                bus.f_req = 1'b0;
                bus.l_req = 1'b0;
            end
            @(negedge clk);
            if (i < 4) begin
                check_val("rr_f_gnt", 32'(bus.f_gnt), 32'((i % 2) == 1));
                check_val("rr_l_gnt", 32'(bus.l_gnt), 32'((i % 2) == 0));
            end
            if (i >= 2) begin
                check_val("rr_l_rvalid", 32'(bus.l_rvalid), 32'((i % 2) == 0));
                check_val("rr_f_rvalid", 32'(bus.f_rvalid), 32'((i % 2) == 1));
                if ((i % 2) == 0) check_val("rr_l_rdata", bus.l_rdata, 32'hA000_0005);
                else              check_val("rr_f_rdata", bus.f_rdata, 32'hA000_0003);
            end
            step();
        end

        // Lock: fetch blocked, loader writes 0x10, then fetch reads it back
        bus.l_lock = 1'b1; bus.f_req = 1'b1; bus.f_addr = 32'h10;
        @(negedge clk);
        check_val("lk_f_gnt_idle", 32'(bus.f_gnt), 32'd0);
        check_val("lk_l_gnt_idle", 32'(bus.l_gnt), 32'd0);
        check_val("lk_mem_we_idle", 32'(bus.mem_we), 32'd0);
        step();
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h10; bus.l_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_val("lk_l_gnt", 32'(bus.l_gnt), 32'd1);
        check_val("lk_f_gnt", 32'(bus.f_gnt), 32'd0);
        check_val("lk_mem_we", 32'(bus.mem_we), 32'd1);
        check_val("lk_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check_val("lk_mem_addr", bus.mem_addr, 32'h10);
        step();
        bus.l_req = 1'b0; bus.l_we = 1'b0; bus.l_lock = 1'b0;
        @(negedge clk);
        check_val("ul_f_gnt", 32'(bus.f_gnt), 32'd1);
        check_val("ul_mem_we", 32'(bus.mem_we), 32'd0);
        check_val("ul_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        step();
        bus.f_req = 1'b0;
        @(negedge clk);
        check_val("raw_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        step();
        @(negedge clk);
        check_val("raw_f_rvalid", 32'(bus.f_rvalid), 32'd1);
        check_val("raw_f_rdata", bus.f_rdata, 32'hDEAD_BEEF);
        check_val("raw_l_rvalid2", 32'(bus.l_rvalid), 32'd0);
        step();

        // Alias 0x44 -> word 1; lock raised after grant must not cancel it
        bus.f_req = 1'b1; bus.f_addr = 32'h44;
        @(negedge clk);
        check_val("al_f_gnt", 32'(bus.f_gnt), 32'd1);
        check_val("al_mem_addr", bus.mem_addr, 32'h4);
        step();
        bus.f_req = 1'b0; bus.l_lock = 1'b1;
        step();
        @(negedge clk);
        check_val("al_f_rvalid", 32'(bus.f_rvalid), 32'd1);
        check_val("al_f_rdata", bus.f_rdata, 32'hA000_0001);
        step();
        bus.l_lock = 1'b0;

        // Reset mid-operation: in-flight fetch dropped, write in reset cycle blocked
        bus.f_req = 1'b1; bus.f_addr = 32'h8;
        @(negedge clk);
        check_val("rm_f_gnt", 32'(bus.f_gnt), 32'd1);
        step();
        bus.f_req = 1'b0; reset = 1'b1;
        bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h18; bus.l_wdata = 32'h1234_5678;
        @(negedge clk);
        check_val("rm_l_gnt", 32'(bus.l_gnt), 32'd0);
        check_val("rm_mem_we", 32'(bus.mem_we), 32'd0);
        step();
        reset = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0;
        @(negedge clk);
        check_val("rm_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        check_val("rm_l_rvalid", 32'(bus.l_rvalid), 32'd0);
        check_val("rm_f_rdata", bus.f_rdata, 32'd0);
        check_val("rm_l_rdata", bus.l_rdata, 32'd0);
        check_val("rm_mem_addr", bus.mem_addr, 32'd0);
        step();

        // First tie after reset goes to loader, then fetch
        bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h1C;
        bus.f_req = 1'b1; bus.f_addr = 32'h18;
        @(negedge clk);
        check_val("t2_l_gnt", 32'(bus.l_gnt), 32'd1);
        check_val("t2_f_gnt", 32'(bus.f_gnt), 32'd0);
        step();
        bus.l_req = 1'b0;
        @(negedge clk);
        check_val("t2_f_gnt2", 32'(bus.f_gnt), 32'd1);
        check_val("t2_mem_addr", bus.mem_addr, 32'h18);
        step();
        bus.f_req = 1'b0;
        @(negedge clk);
        check_val("t2_l_rvalid", 32'(bus.l_rvalid), 32'd1);
        check_val("t2_l_rdata", bus.l_rdata, 32'hA000_0007);
        check_val("t2_f_rvalid", 32'(bus.f_rvalid), 32'd0);
        step();
        @(negedge clk);
        check_val("t2_f_rvalid2", 32'(bus.f_rvalid), 32'd1);
        check_val("t2_f_rdata", bus.f_rdata, 32'hA000_0006);
        step();

        // Idle: nothing granted, responses held, address held
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("id_mem_we", 32'(bus.mem_we), 32'd0);
            check_val("id_gnt", {30'd0, bus.l_gnt, bus.f_gnt}, 32'd0);
            check_val("id_rvalid", {30'd0, bus.l_rvalid, bus.f_rvalid}, 32'd0);
            check_val("id_f_rdata", bus.f_rdata, 32'hA000_0006);
            check_val("id_l_rdata", bus.l_rdata, 32'hA000_0007);
            check_val("id_mem_addr", bus.mem_addr, 32'h18);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single-port, synchronous-read instruction memory between two requesters: the datapath fetch stage (read-only) and the program loader/debug port (read/write).
- Sits between the fetch stage, the loader, and the instruction memory.
- Grants at most one memory access per cycle and routes the 1-cycle-latency read data back to the owner.
- Provides a loader lock so the fetch stage can be frozen during program load.

Parameters:
- NWORDS, (1 << XLEN) / XLEN, number of memory words. Power of two.
- XLEN is not a parameter. It comes from constants.vh, which the module includes.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- f_req  input  1  fetch request valid.
- f_addr  input  XLEN  fetch byte address.
- f_gnt  output  1  fetch request accepted this cycle (combinational).
- f_rvalid  output  1  fetch read data valid (1-cycle pulse).
- f_rdata  output  XLEN  fetch read data. Held between pulses.
- l_req  input  1  loader request valid.
- l_we  input  1  loader write enable (1 = write, 0 = read).
- l_addr  input  XLEN  loader byte address.
- l_wdata  input  XLEN  loader write data.
- l_lock  input  1  while 1, fetch is never granted.
- l_gnt  output  1  loader request accepted this cycle (combinational).
- l_rvalid  output  1  loader read data valid (1-cycle pulse). Never asserted for writes.
- l_rdata  output  XLEN  loader read data. Held between pulses.
- mem_addr  output  XLEN  byte address to memory.
- mem_we  output  1  memory write strobe.
- mem_wdata  output  XLEN  memory write data.
- mem_rdata  input  XLEN  memory read data, valid one cycle after the access.

Behaviour:
- Reset:
  - f_rvalid, l_rvalid, f_rdata, l_rdata = 0.
  - Internal owner register = NONE.
  - Last-grant register = FETCH, so the loader wins the first tie.
  - Combinational outputs follow from registers at reset: f_gnt = l_gnt = 0 unless a request is present after reset deasserts.
- Arbitration is combinational, once per cycle:
  - Only l_req: grant loader.
  - Only f_req and l_lock = 0: grant fetch.
  - f_req with l_lock = 1: fetch is not granted. f_gnt = 0; requester must hold f_req and f_addr.
  - Both requests and l_lock = 0: round-robin. Grant whichever did not win the previous contended-or-uncontended grant (the last-grant register). This bounds each requester's wait to 1 cycle.
  - Neither request: no grant. mem_we = 0, mem_addr = last driven value, last-grant unchanged.
- Memory drive:
  - On grant, mem_addr, mem_we and mem_wdata come from the winner in the same cycle.
  - mem_we = l_we & l_gnt only. Fetch never writes.
- Requester handshake: a requester must hold req and its fields until it sees gnt = 1. gnt = 1 consumes exactly one access.
- Response path (state = owner register, values NONE / FETCH / LOADER_RD):
  - The owner register is loaded on each clock with the grant type: LOADER_RD only for a loader read, NONE for a loader write or no grant.
  - Cycle T+1 after a grant at T:
    - FETCH: f_rvalid = 1, f_rdata <= mem_rdata.
    - LOADER_RD: l_rvalid = 1, l_rdata <= mem_rdata.
  - rvalid and rdata are registered: they capture mem_rdata at the edge ending T+1 and appear at T+1 + 1 clock. Total request-to-rvalid latency is 2 cycles, fixed.
  - rdata is held until the next response to the same requester.
- Back-to-back: a new grant is allowed every cycle, and responses pipeline in order. Owner and response registers form a 2-deep shift so consecutive grants to alternating requesters each receive their own data.
- Read-after-write at the same address:
  - Loader write at T, fetch read at T+1 returns the new data (memory write completes at edge T).
  - Simultaneous same-cycle access is impossible (single grant).
- Address: memory word index = addr[clog2(NWORDS)+1:2]. Upper bits and addr[1:0] are ignored, so addresses wrap modulo NWORDS*4. No misalignment fault.
- l_lock:
  - Asserting it mid-stream does not cancel a fetch already granted; that response still arrives.
  - Deasserting it re-enables fetch the same cycle.
- Reset mid-operation: in-flight responses are discarded (no rvalid after reset). The write in the reset cycle is not issued (gnt forced 0 while reset = 1).

Decomposition:
- Shared package (constants.vh):
  - XLEN.
  - Owner encoding localparams OWN_NONE = 2'd0, OWN_FETCH = 2'd1, OWN_LRD = 2'd2.
- Sub-module rr_arb2: 2-input round-robin arbiter with last-grant register and mask input (used for l_lock).
- The response pipeline stays in imem_arbiter.

Test Plan:
- Reset then f_req = 1, f_addr = 0x8: f_gnt = 1 at T0, mem_addr = 0x8. f_rvalid = 1 at T0+2 with f_rdata = mem[2]. l_rvalid stays 0.
- f_req and l_req both held high for 4 cycles, l_we = 0:
  - Grants alternate L, F, L, F.
  - Rvalids alternate 2 cycles later with the correct per-address data.
  - Neither requester waits more than 1 cycle.
- l_lock = 1, l_req = 1, l_we = 1, l_addr = 0x10, l_wdata = 0xDEADBEEF, f_req = 1:
  - f_gnt = 0 throughout the lock.
  - Next cycle, l_lock = 0 and fetch of 0x10: f_rdata = 0xDEADBEEF, l_rvalid never asserted.
- f_addr = 0x4 + NWORDS*4 aliases to word 1: f_rdata equals the fetch of 0x4.
- Grant fetch at T, assert reset at T+1: no f_rvalid at T+2. All outputs 0 after reset.
- No requests for 5 cycles: mem_we = 0, no gnt, no rvalid. Held f_rdata and l_rdata are unchanged.
